// File: rtl/da_lut_addr_gen_pkg.sv
// Shared constants and types for the DA FIR LUT address generator.
//   DATA_W  : sample width (two's complement)
//   TAPS    : delay-line depth
//   LUT_IN  : taps per LUT (address bits per LUT)
//   NUM_LUT : LUT count, TAPS/LUT_IN
//   state_e : FSM encoding (IDLE/RUN)
//   plane_t : one registered bit-plane with its frame markers
package da_lut_addr_gen_pkg;
  localparam int DATA_W  = 16;
  localparam int TAPS    = 32;
  localparam int LUT_IN  = 4;
  localparam int NUM_LUT = 8;
  localparam int ADDR_W  = NUM_LUT * LUT_IN;
  localparam int BIT_W   = $clog2(DATA_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              vld;
    logic              first;
    logic              last;
    logic [BIT_W-1:0]  idx;
    logic [ADDR_W-1:0] addr;
  } plane_t;
endpackage

// File: rtl/da_lut_addr_gen_tap_line.sv
// da_tap_line: TAPS x DATA_W sample delay line.
//   clk3     : clock, rising edge
//   rst_n    : async active-low reset, zeroes all taps
//   clear    : sync flush, wins over shift_en
//   shift_en : tap[0] <= din, tap[i] <= tap[i-1]
//   din      : new sample
//   taps     : all taps, tap[i] at taps[i]
module da_tap_line
  import da_lut_addr_gen_pkg::*;
(
  input  logic                          clk3,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          shift_en,
  input  logic [DATA_W-1:0]             din,
  output logic [TAPS-1:0][DATA_W-1:0]   taps
);

  // Oldest sample simply falls off the top; the line never wraps.
  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n)        taps <= '0;
    else if (clear)    taps <= '0;
    else if (shift_en) taps <= {taps[TAPS-2:0], din};
  end

endmodule

// File: rtl/da_lut_addr_gen.sv
// da_lut_addr_gen: holds the tap delay line and serializes one bit-plane
// per clk3 cycle, MSB (sign) first, as NUM_LUT LUT addresses.
//   clk3, reset      : clock / async active-low reset
//   clear            : sync flush of taps, FSM and outputs
//   in_valid/in_data : new sample; accepted when in_valid & in_ready
//   in_ready         : IDLE, or RUN on the last plane (back-to-back frames)
//   lut_addr         : LUT j address at [LUT_IN*j +: LUT_IN]
//   addr_valid       : live plane
//   bit_first/last   : plane DATA_W-1 / plane 0
//   bit_idx          : bit index of the current plane
module da_lut_addr_gen
  import da_lut_addr_gen_pkg::*;
(
  input  logic              clk3,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] lut_addr,
  output logic              addr_valid,
  output logic              bit_first,
  output logic              bit_last,
  output logic [BIT_W-1:0]  bit_idx
);

  state_e                      state;
  logic [BIT_W-1:0]            bit_cnt;
  plane_t                      pl;
  logic                        accept;
  logic [TAPS-1:0][DATA_W-1:0] taps;
  logic [TAPS-1:0][DATA_W-1:0] taps_nxt;
  logic [TAPS-1:0][DATA_W-1:0] sel_taps;
  logic [BIT_W-1:0]            sel_bit;
  logic [ADDR_W-1:0]           plane_bits;

  // bit_cnt tracks the plane on the outputs, so the last plane is the
  // cycle where a new sample may enter without a bubble.
  assign in_ready = !clear && (state == IDLE || bit_cnt == '0);
  assign accept   = in_valid && in_ready;

  da_tap_line u_tap_line (
    .clk3     (clk3),
    .rst_n    (reset),
    .clear    (clear),
    .shift_en (accept),
    .din      (in_data),
    .taps     (taps)
  );

  // On accept the first plane must reflect the post-shift taps, which the
  // tap line only holds next cycle, so form them here.
  assign taps_nxt = {taps[TAPS-2:0], in_data};
  assign sel_taps = accept ? taps_nxt : taps;
  assign sel_bit  = accept ? BIT_W'(DATA_W-1) : bit_cnt - BIT_W'(1);

  for (genvar i = 0; i < ADDR_W; i++) begin : g_mux
    assign plane_bits[i] = sel_taps[i][sel_bit];
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pl      <= '0;
    end else if (clear) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pl      <= '0;
    end else if (accept) begin
      state   <= RUN;
      bit_cnt <= BIT_W'(DATA_W-1);
      pl      <= '{vld: 1'b1, first: 1'b1, last: (DATA_W == 1),
                   idx: BIT_W'(DATA_W-1), addr: plane_bits};
    end else if (state == RUN && bit_cnt != '0) begin
      bit_cnt <= bit_cnt - BIT_W'(1);
      pl      <= '{vld: 1'b1, first: 1'b0, last: (bit_cnt == BIT_W'(1)),
                   idx: bit_cnt - BIT_W'(1), addr: plane_bits};
    end else begin
      state   <= IDLE;
      pl      <= '0;
    end
  end

  assign lut_addr   = pl.addr;
  assign addr_valid = pl.vld;
  assign bit_first  = pl.first;
  assign bit_last   = pl.last;
  assign bit_idx    = pl.idx;

endmodule
